// File: rtl/datapath_pkg.sv
// Shared opcode encodings, instruction field positions and the immediate helper
// for the parametrised single-cycle-per-step datapath.
package datapath_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int unsigned OP_MSB = 7;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RS_MSB = 5;
    localparam int unsigned RS_LSB = 4;
    localparam int unsigned RT_MSB = 3;
    localparam int unsigned RT_LSB = 2;
    localparam int unsigned F_MSB  = 1;
    localparam int unsigned F_LSB  = 0;

    // Jump immediate of -1 lands back on the jump itself: treated as halt.
    localparam logic [1:0] HALT_IMM = 2'b11;

    // Sign-extends the 2-bit field; bits at and above w are cleared so the caller
    // can simply truncate to its own width.
    function automatic logic [31:0] sext2(input logic [1:0] f, input int unsigned w);
        logic [31:0] v;
        v = {{30{f[1]}}, f};
        if (w < 32) begin
            v = v & ((32'd1 << w) - 32'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/clk_step_gen.sv
// Divides _CLK into CLK_ and emits a one-cycle step strobe on each 1->0 edge of CLK_.
module clk_step_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic _CLK,
    input  logic RESET,
    input  logic run,
    output logic CLK_,
    output logic step
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q, clk_d;

    always_comb begin
        count_d = count_q;
        clk_d   = clk_q;
        step    = 1'b0;
        if (run) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
                clk_d   = ~clk_q;
                step    = clk_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            clk_q   <= clk_d;
        end
    end

    assign CLK_ = clk_q;

endmodule

// File: rtl/param_datapath.sv
// Parametrised 8-bit-instruction datapath: one instruction per CLK_ period, with
// 4-entry register file, data memory, run/pause, halt detection and register peek.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DMEM_AW = 5,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              _CLK,
    input  logic              RESET,
    input  logic [7:0]        instruction,
    input  logic              run,
    input  logic [1:0]        rf_sel,
    output logic [PC_W-1:0]   PC,
    output logic              CLK_,
    output logic [DMEM_AW-1:0] address,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [DATA_W-1:0] rf_out,
    output logic              halted
);

    localparam int unsigned DEPTH = 2 ** DMEM_AW;

    logic                step, step_en;
    logic [1:0]          op, rs, rt, f;

    logic [DATA_W-1:0]   regs_q [4];
    logic [DATA_W-1:0]   dmem_q [DEPTH];
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DMEM_AW-1:0]  addr_q, ea;
    logic [DATA_W-1:0]   wb_data_q;
    logic                wb_valid_q, halted_q;

    logic [DATA_W-1:0]   rs_val, rt_val, sum, load_val;
    logic                rf_we, dm_we, addr_we, halt_set;
    logic [1:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    clk_step_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_step_gen (
        ._CLK  (_CLK),
        .RESET (RESET),
        .run   (run),
        .CLK_  (CLK_),
        .step  (step)
    );

    assign op = instruction[OP_MSB:OP_LSB];
    assign rs = instruction[RS_MSB:RS_LSB];
    assign rt = instruction[RT_MSB:RT_LSB];
    assign f  = instruction[F_MSB:F_LSB];

    always_comb begin
        step_en  = step & ~halted_q;
        rs_val   = regs_q[rs];
        rt_val   = regs_q[rt];
        sum      = rs_val + rt_val;
        // Address arithmetic is done at memory-address width so it wraps mod depth
        // regardless of how DATA_W compares with DMEM_AW.
        ea       = DMEM_AW'(rs_val) + DMEM_AW'(sext2(f, DMEM_AW));
        load_val = dmem_q[ea];

        rf_we    = 1'b0;
        rf_waddr = f;
        rf_wdata = sum;
        dm_we    = 1'b0;
        addr_we  = 1'b0;
        halt_set = 1'b0;
        pc_d     = pc_q + PC_W'(1);

        if (step_en) begin
            case (op)
                OP_ADD: begin
                    rf_we    = 1'b1;
                    rf_waddr = f;
                    rf_wdata = sum;
                end
                OP_LW: begin
                    rf_we    = 1'b1;
                    rf_waddr = rt;
                    rf_wdata = load_val;
                    addr_we  = 1'b1;
                end
                OP_SW: begin
                    dm_we   = 1'b1;
                    addr_we = 1'b1;
                end
                OP_J: begin
                    if (f == HALT_IMM) begin
                        pc_d     = pc_q;
                        halt_set = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(1) + PC_W'(sext2(f, PC_W));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            pc_q       <= '0;
            addr_q     <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            wb_valid_q <= rf_we;
            if (rf_we) begin
                wb_data_q <= rf_wdata;
            end
            if (addr_we) begin
                addr_q <= ea;
            end
            if (step_en) begin
                pc_q <= pc_d;
            end
            if (halt_set) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Memory comes out of reset holding its own index, so loads are observable
    // without a preceding store.
    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dmem_q[i] <= DATA_W'(i);
            end
        end else if (dm_we) begin
            dmem_q[ea] <= rt_val;
        end
    end

    assign PC       = pc_q;
    assign address  = addr_q;
    assign wb_data  = wb_data_q;
    assign wb_valid = wb_valid_q;
    assign rf_out   = regs_q[rf_sel];
    assign halted   = halted_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath with CLK_DIV=1: one step every two _CLK cycles.
module tb_param_datapath;

    logic       _CLK = 1'b0;
    logic       RESET;
    logic [7:0] instruction;
    logic       run;
    logic [1:0] rf_sel;
    logic [7:0] PC;
    logic       CLK_;
    logic [4:0] address;
    logic [7:0] wb_data;
    logic       wb_valid;
    logic [7:0] rf_out;
    logic       halted;

    logic [7:0] prog [256];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    param_datapath #(
        .DATA_W  (8),
        .PC_W    (8),
        .DMEM_AW (5),
        .CLK_DIV (1)
    ) dut (
        ._CLK        (_CLK),
        .RESET       (RESET),
        .instruction (instruction),
        .run         (run),
        .rf_sel      (rf_sel),
        .PC          (PC),
        .CLK_        (CLK_),
        .address     (address),
        .wb_data     (wb_data),
        .wb_valid    (wb_valid),
        .rf_out      (rf_out),
        .halted      (halted)
    );

    always #5 _CLK = ~_CLK;

    // External instruction source
    always @(posedge CLK_) instruction = prog[PC];

    task automatic cycles(input int n);
        repeat (n) @(negedge _CLK);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic hold_reset();
        RESET = 1'b1;
        cycles(2);
        RESET = 1'b0;
    endtask

    task automatic peek(input logic [1:0] idx, output logic [7:0] val);
        rf_sel = idx;
        #1;
        val = rf_out;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        fill_nop();
        run = 1'b1;
        RESET = 1'b1;
        cycles(3);
        n_vec++; if (PC !== 8'd0) begin n_err++; $display("FAIL rst_pc got=%0d exp=0", PC); end
        n_vec++; if (CLK_ !== 1'b0) begin n_err++; $display("FAIL rst_clk got=%0b exp=0", CLK_); end
        n_vec++; if (address !== 5'd0) begin n_err++; $display("FAIL rst_addr got=%0d exp=0", address); end
        n_vec++; if (wb_data !== 8'd0) begin n_err++; $display("FAIL rst_wbd got=%0d exp=0", wb_data); end
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wbv got=%0b exp=0", wb_valid); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halt got=%0b exp=0", halted); end
        for (int r = 0; r < 4; r++) begin
            peek(2'(r), v);
            n_vec++; if (v !== 8'd0) begin n_err++; $display("FAIL rst_r%0d got=%0d exp=0", r, v); end
        end
        RESET = 1'b0;
    endtask

    task automatic test_first_step();
        logic [7:0] v;
        fill_nop();
        prog[0] = 8'b01000101;
        hold_reset();
        cycles(1);
        n_vec++; if (CLK_ !== 1'b1) begin n_err++; $display("FAIL t1_clk_rise got=%0b exp=1", CLK_); end
        n_vec++; if (PC !== 8'd0) begin n_err++; $display("FAIL t1_no_early_step got=%0d exp=0", PC); end
        cycles(1);
        n_vec++; if (PC !== 8'd1) begin n_err++; $display("FAIL t1_pc got=%0d exp=1", PC); end
        n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL t1_wbv got=%0b exp=1", wb_valid); end
        n_vec++; if (wb_data !== 8'd1) begin n_err++; $display("FAIL t1_wbd got=%0d exp=1", wb_data); end
        n_vec++; if (address !== 5'd1) begin n_err++; $display("FAIL t1_addr got=%0d exp=1", address); end
        peek(2'd1, v);
        n_vec++; if (v !== 8'd1) begin n_err++; $display("FAIL t1_r1 got=%0d exp=1", v); end
        cycles(1);
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL t1_wbv_pulse got=%0b exp=0", wb_valid); end
    endtask

    task automatic test_program();
        logic [7:0] v;
        logic       prev;
        int unsigned toggles;
        fill_nop();
        prog[0] = 8'b01000101;
        prog[1] = 8'b00010110;
        prog[2] = 8'b10001011;
        prog[3] = 8'b01001111;
        prog[4] = 8'b11000011;
        hold_reset();
        cycles(4);
        peek(2'd2, v);
        n_vec++; if (v !== 8'd2) begin n_err++; $display("FAIL t2_r2 got=%0d exp=2", v); end
        cycles(2);
        n_vec++; if (address !== 5'd31) begin n_err++; $display("FAIL t2_sw_addr got=%0d exp=31", address); end
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL t2_sw_wbv got=%0b exp=0", wb_valid); end
        cycles(2);
        peek(2'd3, v);
        n_vec++; if (v !== 8'd2) begin n_err++; $display("FAIL t2_r3 got=%0d exp=2", v); end
        n_vec++; if (wb_data !== 8'd2) begin n_err++; $display("FAIL t2_lw_wbd got=%0d exp=2", wb_data); end
        cycles(2);
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL t2_halted got=%0b exp=1", halted); end
        n_vec++; if (PC !== 8'd4) begin n_err++; $display("FAIL t2_halt_pc got=%0d exp=4", PC); end
        prev = CLK_;
        toggles = 0;
        for (int c = 0; c < 40; c++) begin
            cycles(1);
            if (CLK_ !== prev) toggles++;
            prev = CLK_;
            n_vec++; if (PC !== 8'd4 || wb_valid !== 1'b0) begin
                n_err++; $display("FAIL t2_frozen c=%0d got pc=%0d wbv=%0b exp pc=4 wbv=0", c, PC, wb_valid);
            end
        end
        n_vec++; if (toggles !== 40) begin n_err++; $display("FAIL t2_clk_toggles got=%0d exp=40", toggles); end
        peek(2'd3, v);
        n_vec++; if (v !== 8'd2 || halted !== 1'b1) begin
            n_err++; $display("FAIL t2_hold got r3=%0d halt=%0b exp r3=2 halt=1", v, halted);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        logic [7:0] exp_v;
        fill_nop();
        prog[0] = 8'b01000101;
        for (int i = 1; i <= 8; i++) prog[i] = 8'b00010101;
        hold_reset();
        cycles(2);
        exp_v = 8'd1;
        for (int k = 2; k <= 9; k++) begin
            cycles(2);
            exp_v = exp_v + exp_v;
            peek(2'd1, v);
            n_vec++; if (v !== exp_v || wb_data !== exp_v) begin
                n_err++; $display("FAIL t3_add%0d got r1=%0d wbd=%0d exp=%0d", k - 1, v, wb_data, exp_v);
            end
        end
        n_vec++; if (wb_data !== 8'd0 || wb_valid !== 1'b1) begin
            n_err++; $display("FAIL t3_wrap got wbd=%0d wbv=%0b exp wbd=0 wbv=1", wb_data, wb_valid);
        end
    endtask

    task automatic test_pc_wrap();
        fill_nop();
        prog[255] = 8'b11000001;
        hold_reset();
        cycles(510);
        n_vec++; if (PC !== 8'd255) begin n_err++; $display("FAIL t3_pc255 got=%0d exp=255", PC); end
        cycles(2);
        n_vec++; if (PC !== 8'd1) begin n_err++; $display("FAIL t3_jwrap got=%0d exp=1", PC); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL t3_nohalt got=%0b exp=0", halted); end
    endtask

    task automatic test_back_jump();
        fill_nop();
        prog[3] = 8'b11000010;
        hold_reset();
        cycles(6);
        n_vec++; if (PC !== 8'd3) begin n_err++; $display("FAIL t4_pc3 got=%0d exp=3", PC); end
        cycles(2);
        n_vec++; if (PC !== 8'd2) begin n_err++; $display("FAIL t4_back got=%0d exp=2", PC); end
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL t4_wbv got=%0b exp=0", wb_valid); end
        cycles(2);
        n_vec++; if (PC !== 8'd3 || wb_valid !== 1'b1) begin
            n_err++; $display("FAIL t4_loop got pc=%0d wbv=%0b exp pc=3 wbv=1", PC, wb_valid);
        end
    endtask

    task automatic test_pause();
        fill_nop();
        hold_reset();
        cycles(3);
        n_vec++; if (CLK_ !== 1'b1 || PC !== 8'd1) begin
            n_err++; $display("FAIL t5_pre got clk=%0b pc=%0d exp clk=1 pc=1", CLK_, PC);
        end
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycles(1);
            n_vec++; if (CLK_ !== 1'b1 || PC !== 8'd1) begin
                n_err++; $display("FAIL t5_frozen c=%0d got clk=%0b pc=%0d exp clk=1 pc=1", c, CLK_, PC);
            end
        end
        run = 1'b1;
        cycles(1);
        n_vec++; if (PC !== 8'd2 || CLK_ !== 1'b0) begin
            n_err++; $display("FAIL t5_resume got pc=%0d clk=%0b exp pc=2 clk=0", PC, CLK_);
        end
        cycles(2);
        n_vec++; if (PC !== 8'd3) begin n_err++; $display("FAIL t5_cadence got=%0d exp=3", PC); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        fill_nop();
        prog[0] = 8'b01000101;
        prog[1] = 8'b10000111;
        hold_reset();
        cycles(6);
        peek(2'd1, v);
        n_vec++; if (PC !== 8'd3 || v !== 8'd1) begin
            n_err++; $display("FAIL t6_pre got pc=%0d r1=%0d exp pc=3 r1=1", PC, v);
        end
        cycles(1);
        n_vec++; if (CLK_ !== 1'b1) begin n_err++; $display("FAIL t6_clk_high got=%0b exp=1", CLK_); end
        RESET = 1'b1;
        #1;
        peek(2'd1, v);
        n_vec++; if (PC !== 8'd0 || CLK_ !== 1'b0 || v !== 8'd0) begin
            n_err++; $display("FAIL t6_async got pc=%0d clk=%0b r1=%0d exp 0 0 0", PC, CLK_, v);
        end
        prog[0] = 8'b01001111;
        cycles(1);
        RESET = 1'b0;
        cycles(1);
        peek(2'd3, v);
        n_vec++; if (PC !== 8'd0 || v !== 8'd0) begin
            n_err++; $display("FAIL t6_cycle1 got pc=%0d r3=%0d exp pc=0 r3=0", PC, v);
        end
        cycles(1);
        peek(2'd3, v);
        n_vec++; if (PC !== 8'd1 || v !== 8'd31) begin
            n_err++; $display("FAIL t6_dmem31 got pc=%0d r3=%0d exp pc=1 r3=31", PC, v);
        end
        n_vec++; if (address !== 5'd31 || wb_data !== 8'd31) begin
            n_err++; $display("FAIL t6_lw got addr=%0d wbd=%0d exp 31 31", address, wb_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        instruction = 8'h00;
        rf_sel = 2'd0;
        run = 1'b1;
        RESET = 1'b1;
        test_reset();
        test_first_step();
        test_program();
        test_overflow();
        test_pc_wrap();
        test_back_jump();
        test_pause();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
- Parametrised successor of the 8-bit lab datapath.
- Executes one 8-bit instruction per divided-clock period: fetch PC, decode, 4-entry register file, data memory, ALU, PC update.
- Generates its own divided clock `CLK_` for the external instruction source; that source drives `instruction` = imem[PC] on the rising edge of `CLK_`.
- New over the previous generation: data/PC/memory widths are parameters; adds run/pause, halt detection and a register-observation port.

Parameters:
- DATA_W, 8: register and data-memory word width (>=2).
- PC_W, 8: program-counter width.
- DMEM_AW, 5: data-memory address width; depth = 2**DMEM_AW.
- CLK_DIV, 2: `_CLK` cycles per half-period of `CLK_` (>=1).

Ports:
- _CLK  in  1  system clock. Single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- instruction  in  8  instruction at the current PC; must be stable at each step edge.
- run  in  1  1 = divider and execution advance; 0 = pause.
- rf_sel  in  2  register index to observe.
- PC  out  PC_W  current program counter.
- CLK_  out  1  divided clock.
- address  out  DMEM_AW  last data-memory address used.
- wb_data  out  DATA_W  last value written to the register file.
- wb_valid  out  1  one-`_CLK` pulse on each register write.
- rf_out  out  DATA_W  regs[rf_sel], combinational.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (async), all values:
  - PC=0, CLK_=0, divider count=0, address=0, wb_data=0, wb_valid=0, halted=0.
  - regs[0..3]=0.
  - dmem[i]=i mod 2**DATA_W.
- Divider:
  - When run=1, the count increments each `_CLK`.
  - At count==CLK_DIV-1: count returns to 0 and CLK_ toggles.
  - run=0 freezes both count and CLK_.
- Step strobe: asserted on the `_CLK` edge where CLK_ toggles 1->0.
  - First step occurs 2*CLK_DIV `_CLK` cycles after reset release.
  - Steps repeat every 2*CLK_DIV cycles.
  - All architectural state changes occur only on a step edge.
- Instruction fields:
  - op=[7:6], rs=[5:4], rt=[3:2], f=[1:0].
  - imm = sign-extended f, range -2..+1.
- op 00 ADD: regs[f] <= regs[rs]+regs[rt], modulo 2**DATA_W; wb_data <= sum; PC+1.
- op 01 LW:
  - ea = (regs[rs]+imm) mod 2**DMEM_AW.
  - regs[rt] <= dmem[ea]; address <= ea; wb_data <= loaded value; PC+1.
- op 10 SW: dmem[ea] <= regs[rt]; address <= ea; PC+1; no register write, no wb_valid.
- op 11 J: PC <= PC+1+imm, modulo 2**PC_W.
  - f=2'b11 is a jump-to-self: PC unchanged, halted <= 1.
- PC after 2**PC_W-1 wraps to 0.
- wb_valid is 1 for exactly the `_CLK` cycle following a step that wrote a register; otherwise 0.
- Register reads use pre-step values; a destination that is also a source yields the old value.
- A store followed by a load to the same ea on the next step returns the stored value.
- halted=1:
  - Steps are suppressed; CLK_ keeps toggling if run=1.
  - PC, regs and dmem are frozen.
  - Only RESET clears the flag.
- RESET asserted mid-period (including while CLK_=1): immediate return to reset state; any in-flight step is discarded.
- run deasserted on the cycle a step would occur: no step; it resumes with the same count when run returns.

Decomposition:
- Package `datapath_pkg`:
  - OP_ADD/OP_LW/OP_SW/OP_J localparams.
  - Field bit positions.
  - Function sext2(f, W).
  - HALT_IMM=2'b11.
- Sub-module `clk_step_gen(CLK_DIV)`:
  - Inputs: _CLK, RESET, run.
  - Outputs: CLK_, step.
- Register file, dmem, ALU and PC logic stay inline in param_datapath.

Test Plan (DATA_W=8, PC_W=8, DMEM_AW=5, CLK_DIV=1; bench drives instruction=prog[PC] on posedge CLK_, run=1):
1. Reset then first step with prog[0]=01000101 (LW r1,1(r0)) -> first step at cycle 2; regs[1]=1, address=1, wb_data=1, wb_valid one-cycle pulse, PC=1.
2. Program 01000101, 00010110, 10001011, 01001111, 11000011 -> r2=2; dmem[31]=2 with address=31; r3=2, wb_data=2; halted=1 with PC=4 held for 20 further CLK_ periods.
3. Overflow and wrap:
   - Via repeated ADD r1=r1+r1 from r1=1: after the 8th add, r1 wraps 128->0 and wb_data=0.
   - Jump wrap: a J with imm=+1 at PC=255 -> PC wraps to 1.
4. Backward jump: at PC=3, instruction 11000010 (imm=-2) -> PC=2 next step; no register write, wb_valid stays 0.
5. Pause: drop run for 10 cycles mid-period -> CLK_ and PC frozen; after run=1 the remaining count completes and the step lands exactly 10 cycles late.
6. Reset mid-operation: assert RESET while CLK_=1 after PC=3 -> PC=0, CLK_=0, regs=0, dmem[31]=31 immediately; next step again at cycle 2 after release.
